// File: rtl/isp_pkg.sv
// Shared ISP definitions: default pixel width, output mode encoding and sync helper.
package isp_pkg;

  localparam int unsigned ISP_DW = 8;

  localparam logic MODE_MASK = 1'b0;
  localparam logic MODE_DIFF = 1'b1;

  typedef enum logic {
    PIX_MASK = MODE_MASK,
    PIX_DIFF = MODE_DIFF
  } pix_mode_e;

  function automatic logic sync_active(input logic sync, input logic pol);
    return (sync == pol);
  endfunction

endpackage

// File: rtl/diff_pic_mask_if.sv
// Video in/out bundle of the frame-difference stage; master drives pixels, slave is the DUT.
interface diff_pic_mask_if #(
  parameter int unsigned DW    = isp_pkg::ISP_DW,
  parameter int unsigned CNT_W = 22
);
  logic             hsync_i;
  logic             vsync_i;
  logic             de_i;
  logic [DW-1:0]    new_pic;
  logic [DW-1:0]    last_pic;
  logic [DW-1:0]    diff_thr;
  logic [CNT_W-1:0] area_thr;
  logic             mode_i;

  logic             hsync_o;
  logic             vsync_o;
  logic             de_o;
  logic [DW-1:0]    diff_data;
  logic [CNT_W-1:0] motion_cnt_o;
  logic             cnt_valid_o;
  logic             motion_flag_o;

  modport master (
    output hsync_i, vsync_i, de_i, new_pic, last_pic, diff_thr, area_thr, mode_i,
    input  hsync_o, vsync_o, de_o, diff_data, motion_cnt_o, cnt_valid_o, motion_flag_o
  );

  modport slave (
    input  hsync_i, vsync_i, de_i, new_pic, last_pic, diff_thr, area_thr, mode_i,
    output hsync_o, vsync_o, de_o, diff_data, motion_cnt_o, cnt_valid_o, motion_flag_o
  );

endinterface

// File: rtl/abs_diff_reg.sv
// Registered absolute difference |a - b| of two unsigned DW-bit pixels.
module abs_diff_reg #(
  parameter int unsigned DW = isp_pkg::ISP_DW
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] ad
);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ad <= '0;
    end else if (a >= b) begin
      ad <= a - b;
    end else begin
      ad <= b - a;
    end
  end

endmodule

// File: rtl/diff_pic_mask.sv
// Frame-difference stage: 2-cycle |diff| mask/threshold pipe plus per-frame changed-pixel count.
module diff_pic_mask
  import isp_pkg::*;
#(
  parameter int unsigned DW     = ISP_DW,
  parameter int unsigned CNT_W  = 22,
  parameter bit          VS_POL = 1'b1
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  diff_pic_mask_if.slave  pic
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DW-1:0]    ad_s1;
  logic             hs_s1;
  logic             vs_s1;
  logic             de_s1;
  logic [DW-1:0]    thr_q;
  pix_mode_e        mode_q;
  logic             frame_seen;
  logic [CNT_W-1:0] acc;

  logic             in_start;
  logic             frame_start;
  logic             chg;
  logic [DW-1:0]    pix_d;
  logic [CNT_W-1:0] acc_next;

  abs_diff_reg #(.DW(DW)) u_abs_diff (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .a         (pic.new_pic),
    .b         (pic.last_pic),
    .ad        (ad_s1)
  );

  // vs_s1 is vsync_i one cycle late, so it doubles as the input-side edge reference;
  // vsync_o plays the same role for the stage-2 frame boundary.
  assign in_start    = sync_active(pic.vsync_i, VS_POL) & ~sync_active(vs_s1, VS_POL);
  assign frame_start = sync_active(vs_s1, VS_POL) & ~sync_active(pic.vsync_o, VS_POL);
  assign chg         = de_s1 & (ad_s1 >= thr_q);

  always_comb begin
    pix_d = '0;
    if (chg) begin
      pix_d = (mode_q == PIX_DIFF) ? ad_s1 : '0;
    end else if (de_s1 && (mode_q == PIX_MASK)) begin
      pix_d = '1;
    end
  end

  always_comb begin
    acc_next = acc;
    if (chg && (acc != CNT_MAX)) begin
      acc_next = acc + CNT_W'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hs_s1  <= 1'b0;
      vs_s1  <= 1'b0;
      de_s1  <= 1'b0;
      thr_q  <= '0;
      mode_q <= PIX_MASK;
    end else begin
      hs_s1 <= pic.hsync_i;
      vs_s1 <= pic.vsync_i;
      de_s1 <= pic.de_i;
      if (in_start) begin
        thr_q  <= pic.diff_thr;
        mode_q <= pix_mode_e'(pic.mode_i);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pic.hsync_o   <= 1'b0;
      pic.vsync_o   <= 1'b0;
      pic.de_o      <= 1'b0;
      pic.diff_data <= '0;
    end else begin
      pic.hsync_o   <= hs_s1;
      pic.vsync_o   <= vs_s1;
      pic.de_o      <= de_s1;
      pic.diff_data <= pix_d;
    end
  end

  // A pixel changed on the boundary cycle already belongs to the new frame.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      acc               <= '0;
      frame_seen        <= 1'b0;
      pic.motion_cnt_o  <= '0;
      pic.motion_flag_o <= 1'b0;
      pic.cnt_valid_o   <= 1'b0;
    end else begin
      pic.cnt_valid_o <= 1'b0;
      if (frame_start) begin
        if (frame_seen) begin
          pic.motion_cnt_o  <= acc;
          pic.motion_flag_o <= (acc >= pic.area_thr);
          pic.cnt_valid_o   <= 1'b1;
        end
        acc        <= CNT_W'(chg);
        frame_seen <= 1'b1;
      end else begin
        acc <= acc_next;
      end
    end
  end

endmodule

// File: tb/tb_diff_pic_mask.sv
// Randomised and directed checks of diff_pic_mask against a frame-level reference model.
module tb_diff_pic_mask;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;

  always #5 sys_clk = ~sys_clk;

  diff_pic_mask_if #(.DW(8), .CNT_W(22)) ifc8 ();
  diff_pic_mask_if #(.DW(8), .CNT_W(3))  ifc3 ();

  diff_pic_mask #(.DW(8), .CNT_W(22), .VS_POL(1'b1)) u_dut8 (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .pic       (ifc8)
  );

  diff_pic_mask #(.DW(8), .CNT_W(3), .VS_POL(1'b1)) u_dut3 (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .pic       (ifc3)
  );

  typedef struct {
    bit      hs, vs, de, valid, f8, f3;
    int      data;
    longint  c8, c3;
  } exp_t;

  exp_t   q[$];
  int     n_checks = 0;
  int     n_errors = 0;

  int     diff_thr_v = 0;
  bit     mode_v     = 0;
  longint area8_v    = 0;
  longint area3_v    = 0;
  int     mid_at     = -1;
  int     mid_thr    = 0;
  int     rst_at     = -1;

  // frame-level model state
  bit     m_vs_prev, m_seen, m_mode, m_f8, m_f3;
  int     m_thr;
  longint m_count, m_c8, m_c3;

  longint got_valid, got_c8, got_c3, got_f8, got_f3;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v, input longint m);
    return (v > m) ? m : v;
  endfunction

  task automatic model_reset();
    m_vs_prev = 0; m_seen = 0; m_mode = 0; m_f8 = 0; m_f3 = 0;
    m_thr = 0; m_count = 0; m_c8 = 0; m_c3 = 0;
    q.delete();
  endtask

  task automatic step(input bit hs, input bit vs, input bit de, input int np, input int lp);
    exp_t e, o;
    bit   start, chg;
    int   ad;
    ifc8.hsync_i = hs; ifc8.vsync_i = vs; ifc8.de_i = de;
    ifc8.new_pic = 8'(np); ifc8.last_pic = 8'(lp);
    ifc8.diff_thr = 8'(diff_thr_v); ifc8.mode_i = mode_v; ifc8.area_thr = 22'(area8_v);
    ifc3.hsync_i = hs; ifc3.vsync_i = vs; ifc3.de_i = de;
    ifc3.new_pic = 8'(np); ifc3.last_pic = 8'(lp);
    ifc3.diff_thr = 8'(diff_thr_v); ifc3.mode_i = mode_v; ifc3.area_thr = 3'(area3_v);

    start = vs && !m_vs_prev;
    m_vs_prev = vs;
    if (start) begin
      m_thr  = diff_thr_v;
      m_mode = mode_v;
    end
    ad  = (np > lp) ? np - lp : lp - np;
    chg = de && (ad >= m_thr);
    e.valid = 0;
    if (start) begin
      if (m_seen) begin
        e.valid = 1;
        m_c8 = sat(m_count, 64'd4194303);
        m_c3 = sat(m_count, 64'd7);
        m_f8 = (m_c8 >= area8_v);
        m_f3 = (m_c3 >= area3_v);
      end
      m_count = chg;
      m_seen  = 1;
    end else begin
      m_count += chg;
    end
    e.hs = hs; e.vs = vs; e.de = de;
    if (!de)        e.data = 0;
    else if (m_mode) e.data = chg ? ad : 0;
    else            e.data = chg ? 0 : 255;
    e.c8 = m_c8; e.c3 = m_c3; e.f8 = m_f8; e.f3 = m_f3;
    q.push_back(e);

    @(posedge sys_clk);
    #1;
    if (q.size() == 2) begin
      o = q.pop_front();
      check("hsync_o", ifc8.hsync_o, o.hs);
      check("vsync_o", ifc8.vsync_o, o.vs);
      check("de_o",    ifc8.de_o,    o.de);
      check("diff_data", ifc8.diff_data, o.data);
      check("cnt_valid", ifc8.cnt_valid_o, o.valid);
      check("motion_cnt", ifc8.motion_cnt_o, o.c8);
      check("motion_flag", ifc8.motion_flag_o, o.f8);
      check("diff_data_w3", ifc3.diff_data, o.data);
      check("cnt_valid_w3", ifc3.cnt_valid_o, o.valid);
      check("motion_cnt_w3", ifc3.motion_cnt_o, o.c3);
      check("motion_flag_w3", ifc3.motion_flag_o, o.f3);
    end
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    #1;
    check("rst_hsync",  ifc8.hsync_o, 0);
    check("rst_vsync",  ifc8.vsync_o, 0);
    check("rst_de",     ifc8.de_o, 0);
    check("rst_data",   ifc8.diff_data, 0);
    check("rst_cnt",    ifc8.motion_cnt_o, 0);
    check("rst_valid",  ifc8.cnt_valid_o, 0);
    check("rst_flag",   ifc8.motion_flag_o, 0);
    check("rst_cnt_w3", ifc3.motion_cnt_o, 0);
    model_reset();
    #2;
    sys_rst_n = 1'b1;
  endtask

  // Pixels with index < nchg differ by 100, the rest are identical (directed mode).
  task automatic frame(input int w, input int h, input int nchg, input bit rnd);
    int idx, np, lp;
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    got_valid = ifc8.cnt_valid_o; got_c8 = ifc8.motion_cnt_o; got_f8 = ifc8.motion_flag_o;
    got_c3 = ifc3.motion_cnt_o; got_f3 = ifc3.motion_flag_o;
    step(0, 0, 0, 0, 0);
    idx = 0;
    for (int y = 0; y < h; y++) begin
      step(1, 0, 0, 0, 0);
      for (int x = 0; x < w; x++) begin
        if (idx == mid_at) diff_thr_v = mid_thr;
        if (idx == rst_at) do_reset();
        if (rnd) begin
          np = int'($urandom_range(0, 255));
          case ($urandom_range(0, 3))
            0: lp = np;
            1: begin np = 255; lp = 0; end
            default: lp = int'($urandom_range(0, 255));
          endcase
          if ($urandom_range(0, 5) == 0) step(0, 0, 0, np, lp);
        end else begin
          np = 100;
          lp = (idx < nchg) ? 0 : 100;
        end
        step(0, 0, 1, np, lp);
        idx++;
      end
      step(0, 0, 0, 0, 0);
    end
    step(0, 0, 0, 0, 0);
  endtask

  initial begin
    ifc8.hsync_i = 0; ifc8.vsync_i = 0; ifc8.de_i = 0; ifc8.new_pic = 0; ifc8.last_pic = 0;
    ifc8.diff_thr = 0; ifc8.mode_i = 0; ifc8.area_thr = 0;
    ifc3.hsync_i = 0; ifc3.vsync_i = 0; ifc3.de_i = 0; ifc3.new_pic = 0; ifc3.last_pic = 0;
    ifc3.diff_thr = 0; ifc3.mode_i = 0; ifc3.area_thr = 0;
    model_reset();
    repeat (3) @(posedge sys_clk);
    #1;
    do_reset();

    // binary mask, thr 20
    diff_thr_v = 20; mode_v = 0;
    step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0); step(0, 0, 0, 0, 0);
    step(0, 0, 1, 100, 79);
    step(0, 0, 1, 100, 81);
    check("t1_changed_black", ifc8.diff_data, 8'h00);
    step(0, 0, 0, 0, 0);
    check("t1_unchanged_white", ifc8.diff_data, 8'hFF);
    step(0, 0, 0, 0, 0);

    // thresholded |diff|, thr 10
    diff_thr_v = 10; mode_v = 1;
    step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0); step(0, 0, 0, 0, 0);
    step(0, 0, 1, 5, 200);
    step(0, 0, 1, 50, 45);
    check("t2_diff_195", ifc8.diff_data, 195);
    step(0, 0, 0, 9, 1);
    check("t2_below_thr", ifc8.diff_data, 0);
    step(0, 0, 0, 0, 0);
    check("t2_de_low", ifc8.diff_data, 0);

    // frame counting, saturation at CNT_W=3
    do_reset();
    diff_thr_v = 20; mode_v = 0; area8_v = 5; area3_v = 5;
    frame(4, 4, 0, 0);
    check("t4_first_no_valid", got_valid, 0);
    frame(4, 4, 5, 0);
    check("t4_f0_valid", got_valid, 1);
    check("t4_f0_cnt", got_c8, 0);
    check("t4_f0_flag", got_f8, 0);
    frame(4, 4, 16, 0);
    check("t4_f5_cnt", got_c8, 5);
    check("t4_f5_flag", got_f8, 1);
    frame(4, 4, 12, 0);
    check("t4_f16_valid", got_valid, 1);
    check("t4_f16_cnt", got_c8, 16);
    check("t4_f16_flag", got_f8, 1);
    check("t4_f16_cnt_w3", got_c3, 7);
    frame(4, 4, 0, 0);
    check("t5_cnt12", got_c8, 12);
    check("t5_sat_w3", got_c3, 7);

    // threshold change mid-frame takes effect at next frame start
    mid_at = 8; mid_thr = 200;
    frame(4, 4, 16, 0);
    mid_at = -1;
    frame(4, 4, 16, 0);
    check("t3_old_thr_cnt", got_c8, 16);
    frame(4, 4, 0, 0);
    check("t3_new_thr_cnt", got_c8, 0);

    // reset mid-frame
    diff_thr_v = 20;
    rst_at = 6;
    frame(4, 4, 16, 0);
    rst_at = -1;
    frame(4, 4, 5, 0);
    check("t6_no_valid_after_rst", got_valid, 0);
    frame(4, 4, 0, 0);
    check("t6_valid", got_valid, 1);
    check("t6_cnt", got_c8, 5);

    // randomised frames incl. thr 0 / max and area 0
    for (int f = 0; f < 10; f++) begin
      case ($urandom_range(0, 2))
        0: diff_thr_v = 0;
        1: diff_thr_v = 255;
        default: diff_thr_v = int'($urandom_range(0, 255));
      endcase
      mode_v  = 1'($urandom_range(0, 1));
      area8_v = ($urandom_range(0, 2) == 0) ? 0 : longint'($urandom_range(0, 16));
      area3_v = longint'($urandom_range(0, 7));
      frame(int'($urandom_range(3, 6)), int'($urandom_range(2, 4)), 0, 1);
    end
    frame(4, 2, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
